srai_accel_axi_lite_regfile: RTL and testbench

SRAI_ACCEL_AXI_LITE_REGFILE -- requirements
Module: srai_accel_axi_lite_regfile

---
 rtl/srai_accel_regfile_pkg.sv | 7 +
 rtl/srai_accel_axi_lite_wr_ctrl.sv | 86 ++++++++
 rtl/srai_accel_axi_lite_regfile.sv | 87 ++++++++
 tb/tb_srai_accel_axi_lite_regfile.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/srai_accel_regfile_pkg.sv
// srai_accel_regfile_pkg: shared AXI response codes and FSM state types for the register file
package srai_accel_regfile_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
endpackage

// File: rtl/srai_accel_axi_lite_wr_ctrl.sv
// srai_accel_axi_lite_wr_ctrl: AXI-Lite write path with AW/W capture, decode, byte merge and B response
module srai_accel_axi_lite_wr_ctrl
  import srai_accel_regfile_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic [AW-1:0]          awaddr_i,
  input  logic                   awvalid_i,
  output logic                   awready_o,
  input  logic [DW-1:0]          wdata_i,
  input  logic [DW/8-1:0]        wstrb_i,
  input  logic                   wvalid_i,
  output logic                   wready_o,
  output logic [1:0]             bresp_o,
  output logic                   bvalid_o,
  input  logic                   bready_i,
  output logic [NUM_REGS*DW-1:0] regs_o,
  output logic [NUM_REGS-1:0]    wr_pulse_o
);
  localparam int SW = DW / 8;
  localparam int OFF = $clog2(SW);
  localparam int IXW = AW - OFF;
  w_state_e state_q, state_d;
  logic aw_held_q, w_held_q, aw_hs, w_hs, commit;
  logic [IXW-1:0] idx_q, idx;
  logic [DW-1:0] wdata_q, wdata;
  logic [SW-1:0] wstrb_q, wstrb;
  logic [1:0] bresp_q, bresp_d;
  logic [NUM_REGS-1:0][DW-1:0] regs_q;
  logic unused_aw;
  assign unused_aw = ^awaddr_i[OFF-1:0];
  assign awready_o = en_i && !aw_held_q && state_q == W_IDLE;
  assign wready_o = en_i && !w_held_q && state_q == W_IDLE;
  assign aw_hs = awvalid_i && awready_o;
  assign w_hs = wvalid_i && wready_o;
  // A write commits in the first cycle where both halves are present, held or handshaking now
  assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign idx = aw_held_q ? idx_q : awaddr_i[AW-1:OFF];
  assign wdata = w_held_q ? wdata_q : wdata_i;
  assign wstrb = w_held_q ? wstrb_q : wstrb_i;
  assign bvalid_o = state_q == W_RESP;
  assign bresp_o = bresp_q;
  assign regs_o = regs_q;
  // Decode: only an in-range, writable index produces a strobe
  always_comb begin
    wr_pulse_o = '0;
    for (int i = 0; i < NUM_REGS; i++) wr_pulse_o[i] = commit && idx == IXW'(i) && !RO_MASK[i];
  end
  // Next state: a single outstanding write whose response waits for bready
  always_comb begin
    state_d = state_q == W_IDLE ? (commit ? W_RESP : W_IDLE) : (bready_i ? W_IDLE : W_RESP);
    bresp_d = commit ? (|wr_pulse_o ? RESP_OKAY : RESP_SLVERR) : bresp_q;
  end
  // State, half-transaction capture and byte-strobe merge into the register array
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= W_IDLE;
      bresp_q   <= RESP_OKAY;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      regs_q    <= '0;
    end else begin
      state_q   <= state_d;
      bresp_q   <= bresp_d;
      aw_held_q <= (aw_held_q || aw_hs) && !commit;
      w_held_q  <= (w_held_q || w_hs) && !commit;
      if (aw_hs) idx_q <= awaddr_i[AW-1:OFF];
      if (w_hs) begin
        wdata_q <= wdata_i;
        wstrb_q <= wstrb_i;
      end
      for (int i = 0; i < NUM_REGS; i++)
        for (int b = 0; b < SW; b++)
          if (wr_pulse_o[i] && wstrb[b]) regs_q[i][8*b +: 8] <= wdata[8*b +: 8];
    end
  end
endmodule

// File: rtl/srai_accel_axi_lite_regfile.sv
// srai_accel_axi_lite_regfile: AXI-Lite register file with RW registers and read-only status registers
module srai_accel_axi_lite_regfile
  import srai_accel_regfile_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [AW-1:0]          AXI_LITE_awaddr,
  input  logic                   AXI_LITE_awvalid,
  output logic                   AXI_LITE_awready,
  input  logic [DW-1:0]          AXI_LITE_wdata,
  input  logic [DW/8-1:0]        AXI_LITE_wstrb,
  input  logic                   AXI_LITE_wvalid,
  output logic                   AXI_LITE_wready,
  output logic [1:0]             AXI_LITE_bresp,
  output logic                   AXI_LITE_bvalid,
  input  logic                   AXI_LITE_bready,
  input  logic [AW-1:0]          AXI_LITE_araddr,
  input  logic                   AXI_LITE_arvalid,
  output logic                   AXI_LITE_arready,
  output logic [DW-1:0]          AXI_LITE_rdata,
  output logic [1:0]             AXI_LITE_rresp,
  output logic                   AXI_LITE_rvalid,
  input  logic                   AXI_LITE_rready,
  output logic [NUM_REGS*DW-1:0] reg_q,
  input  logic [NUM_REGS*DW-1:0] status_in,
  output logic [NUM_REGS-1:0]    wr_pulse,
  output logic [NUM_REGS-1:0]    rd_pulse
);
  localparam int OFF = $clog2(DW / 8);
  localparam int IXW = AW - OFF;
  r_state_e r_state_q, r_state_d;
  logic en_q, ar_hs;
  logic [IXW-1:0] ar_idx;
  logic [DW-1:0] rsel, rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;
  logic unused_ar;
  assign unused_ar = ^AXI_LITE_araddr[OFF-1:0];
  assign ar_idx = AXI_LITE_araddr[AW-1:OFF];
  assign AXI_LITE_arready = en_q && r_state_q == R_IDLE;
  assign ar_hs = AXI_LITE_arvalid && AXI_LITE_arready;
  assign AXI_LITE_rvalid = r_state_q == R_DATA;
  assign AXI_LITE_rdata = rdata_q;
  assign AXI_LITE_rresp = rresp_q;
  srai_accel_axi_lite_wr_ctrl #(
    .AW(AW), .DW(DW), .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
  ) u_wr (
    .clk_i(aclk), .rst_ni(aresetn), .en_i(en_q),
    .awaddr_i(AXI_LITE_awaddr), .awvalid_i(AXI_LITE_awvalid), .awready_o(AXI_LITE_awready),
    .wdata_i(AXI_LITE_wdata), .wstrb_i(AXI_LITE_wstrb), .wvalid_i(AXI_LITE_wvalid),
    .wready_o(AXI_LITE_wready), .bresp_o(AXI_LITE_bresp), .bvalid_o(AXI_LITE_bvalid),
    .bready_i(AXI_LITE_bready), .regs_o(reg_q), .wr_pulse_o(wr_pulse)
  );
  // Read select: RO slots come from status_in, out-of-range reads see zero and no strobe
  always_comb begin
    rsel = '0;
    rd_pulse = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IXW'(i)) rsel = RO_MASK[i] ? status_in[i*DW +: DW] : reg_q[i*DW +: DW];
      rd_pulse[i] = ar_hs && ar_idx == IXW'(i);
    end
  end
  // Read next state: data is captured at the AR handshake and held until rready
  always_comb begin
    r_state_d = r_state_q == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (AXI_LITE_rready ? R_IDLE : R_DATA);
    rdata_d = ar_hs ? rsel : rdata_q;
    rresp_d = ar_hs ? (|rd_pulse ? RESP_OKAY : RESP_SLVERR) : rresp_q;
  end
  // Read state and a ready enable that stays low until the first edge after reset release
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_q      <= 1'b0;
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      en_q      <= 1'b1;
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end
endmodule

// File: tb/tb_srai_accel_axi_lite_regfile.sv
// tb_srai_accel_axi_lite_regfile: directed checks of the AXI-Lite register file
module tb_srai_accel_axi_lite_regfile;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int N = 16;
  localparam logic [N-1:0] RO = 16'h0008;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;
  logic [N*DW-1:0] reg_q;
  logic [N*DW-1:0] status_in = '0;
  logic [N-1:0] wr_pulse, rd_pulse;
  logic [DW-1:0] exp_r [N];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  srai_accel_axi_lite_regfile #(.AW(AW), .DW(DW), .NUM_REGS(N), .RO_MASK(RO)) dut (
    .aclk(clk), .aresetn(aresetn),
    .AXI_LITE_awaddr(awaddr), .AXI_LITE_awvalid(awvalid), .AXI_LITE_awready(awready),
    .AXI_LITE_wdata(wdata), .AXI_LITE_wstrb(wstrb), .AXI_LITE_wvalid(wvalid), .AXI_LITE_wready(wready),
    .AXI_LITE_bresp(bresp), .AXI_LITE_bvalid(bvalid), .AXI_LITE_bready(bready),
    .AXI_LITE_araddr(araddr), .AXI_LITE_arvalid(arvalid), .AXI_LITE_arready(arready),
    .AXI_LITE_rdata(rdata), .AXI_LITE_rresp(rresp), .AXI_LITE_rvalid(rvalid), .AXI_LITE_rready(rready),
    .reg_q(reg_q), .status_in(status_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );
  task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [N*DW-1:0] exp_flat();
    logic [N*DW-1:0] f;
    for (int i = 0; i < N; i++) f[i*DW +: DW] = exp_r[i];
    return f;
  endfunction
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic drive_wr(input string tag, input logic do_aw, input logic do_w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW/8-1:0] s, input logic [N-1:0] exp_pulse);
    awaddr = a; awvalid = do_aw; wdata = d; wstrb = s; wvalid = do_w;
    #1 chk({tag, "_wr_pulse"}, wr_pulse, exp_pulse);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask
  task automatic finish_b(input string tag, input logic [1:0] exp_resp);
    int n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    chk({tag, "_bvalid"}, bvalid, 1'b1);
    chk({tag, "_bresp"}, bresp, exp_resp);
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask
  task automatic drive_rd(input string tag, input logic [AW-1:0] a, input logic [N-1:0] exp_pulse);
    araddr = a; arvalid = 1'b1;
    #1 chk({tag, "_rd_pulse"}, rd_pulse, exp_pulse);
    tick();
    arvalid = 1'b0;
  endtask
  task automatic finish_r(input string tag, input logic [DW-1:0] exp_data, input logic [1:0] exp_resp);
    int n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    chk({tag, "_rvalid"}, rvalid, 1'b1);
    chk({tag, "_rdata"}, rdata, exp_data);
    chk({tag, "_rresp"}, rresp, exp_resp);
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < N; i++) exp_r[i] = '0;
    repeat (2) tick();
    chk("rst_ready", {awready, wready, arready}, 3'b000);
    chk("rst_valid", {bvalid, rvalid, bresp, rresp, rdata}, '0);
    chk("rst_regs", reg_q, '0);
    chk("rst_pulse", {wr_pulse, rd_pulse}, '0);
    aresetn = 1'b1;
    tick();
    chk("ready_after_rst", {awready, wready, arready}, 3'b111);
    drive_wr("w042", 1'b1, 1'b1, 12'h008, 32'hDEADBEEF, 4'hF, 16'h0004);
    chk("w042_bvalid_next", bvalid, 1'b1);
    chk("w042_pulse_once", wr_pulse, '0);
    exp_r[2] = 32'hDEADBEEF;
    chk("w042_regs", reg_q, exp_flat());
    finish_b("w042", OKAY);
    drive_wr("w043_w", 1'b0, 1'b1, 12'h000, 32'h12345678, 4'h3, 16'h0000);
    chk("w043_wheld", {wready, awready, bvalid}, 3'b010);
    tick();
    drive_wr("w043_aw", 1'b1, 1'b0, 12'h008, 32'h0, 4'h0, 16'h0004);
    exp_r[2] = 32'hDEAD5678;
    chk("w043_regs", reg_q, exp_flat());
    finish_b("w043", OKAY);
    drive_wr("wstrb", 1'b1, 1'b1, 12'h006, 32'h99887766, 4'hA, 16'h0002);
    exp_r[1] = 32'h99007700;
    chk("wstrb_regs", reg_q, exp_flat());
    finish_b("wstrb", OKAY);
    drive_wr("w044", 1'b1, 1'b1, 12'h040, 32'hFFFFFFFF, 4'hF, 16'h0000);
    chk("w044_regs", reg_q, exp_flat());
    finish_b("w044", SLVERR);
    drive_rd("r044", 12'h040, 16'h0000);
    finish_r("r044", 32'h0, SLVERR);
    status_in[3*DW +: DW] = 32'hA5A50001;
    drive_rd("r045", 12'h00C, 16'h0008);
    status_in[3*DW +: DW] = 32'h0;
    finish_r("r045", 32'hA5A50001, OKAY);
    drive_wr("w045", 1'b1, 1'b1, 12'h00C, 32'h11111111, 4'hF, 16'h0000);
    finish_b("w045", SLVERR);
    chk("w045_regs", reg_q, exp_flat());
    drive_rd("r_rw", 12'h008, 16'h0004);
    finish_r("r_rw", 32'hDEAD5678, OKAY);
    awaddr = 12'h008; awvalid = 1'b1; wdata = 32'h0BADCAFE; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 12'h008; arvalid = 1'b1;
    #1 chk("same_cycle_pulses", {wr_pulse, rd_pulse}, {16'h0004, 16'h0004});
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    exp_r[2] = 32'h0BADCAFE;
    for (int k = 0; k < 10; k++) begin
      chk("stall_hold", {bvalid, bresp, rvalid, rresp, rdata, awready, wready, arready},
          {1'b1, OKAY, 1'b1, OKAY, 32'hDEAD5678, 3'b000});
      tick();
    end
    chk("stall_regs", reg_q, exp_flat());
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    chk("stall_release", {bvalid, rvalid, awready, wready, arready}, 5'b00111);
    drive_wr("w047_aw", 1'b1, 1'b0, 12'h004, 32'h0, 4'h0, 16'h0000);
    chk("w047_aw_held", {awready, wready}, 2'b01);
    aresetn = 1'b0;
    for (int i = 0; i < N; i++) exp_r[i] = '0;
    #1 chk("w047_rst_regs", reg_q, exp_flat());
    chk("w047_rst_out", {awready, wready, arready, bvalid, rvalid}, 5'b00000);
    repeat (2) tick();
    aresetn = 1'b1;
    tick();
    chk("w047_ready", {awready, wready, arready}, 3'b111);
    drive_wr("w047_w", 1'b0, 1'b1, 12'h000, 32'h55555555, 4'hF, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      chk("w047_no_b", {bvalid, wr_pulse}, '0);
      tick();
    end
    drive_wr("w047_aw2", 1'b1, 1'b0, 12'h004, 32'h0, 4'h0, 16'h0002);
    exp_r[1] = 32'h55555555;
    chk("w047_regs", reg_q, exp_flat());
    finish_b("w047", OKAY);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
